// File: rtl/rxshift_pkg.sv
// Shared USRT frame constants, receive FSM state encoding and parity helper.
// Used by the receive shifter and kept in step with the transmit side.
package rxshift_pkg;

  localparam int USRT_FRAME_BITS = 11;
  localparam int USRT_DATA_BITS  = 8;

  localparam int BIT_START    = 0;
  localparam int BIT_DATA_LSB = 1;
  localparam int BIT_PARITY   = 9;
  localparam int BIT_STOP     = 10;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4
  } state_e;

  // High when data plus parity bit do not match the selected parity sense.
  function automatic logic parity_err(input logic [USRT_DATA_BITS-1:0] data,
                                      input logic par,
                                      input logic odd);
    return (^{data, par}) ^ odd;
  endfunction

endpackage

// File: rtl/usrt_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with registered
// single-cycle rise and fall pulses derived from the synchronised value.
module usrt_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Synchroniser chain resets to 1 so an idle-high input produces no edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= ~prev_q & sync_q[STAGES-1];
      fall_q <= prev_q & ~sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/rxshift.sv
// USRT receive shifter: samples the serial line on each synchronised bit-clock
// fall, assembles start/D0..D7/parity/stop and hands the byte to the host.
module rxshift
  import rxshift_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic       i_Pclk,
  input  logic       i_Rst_n,
  input  logic       i_Bclk,
  input  logic       i_Rx_Serial,
  input  logic       i_Read,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Overrun,
  output logic       o_Busy
);

  logic                      tick_s;
  logic                      bclk_sync_unused_s;
  logic                      bclk_rise_unused_s;
  logic                      rx_s;
  logic                      commit_s;
  logic [SYNC_STAGES-1:0]    rx_sync_q;
  state_e                    state_q;
  state_e                    state_d;
  logic [2:0]                cnt_q;
  logic [USRT_DATA_BITS-1:0] shift_q;
  logic                      perr_q;
  logic [USRT_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      par_err_q;
  logic                      frame_err_q;
  logic                      overrun_q;
  logic                      busy_q;

  usrt_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk_i  (i_Pclk),
    .rst_ni (i_Rst_n),
    .d_i    (i_Bclk),
    .sync_o (bclk_sync_unused_s),
    .rise_o (bclk_rise_unused_s),
    .fall_o (tick_s)
  );

  assign rx_s     = rx_sync_q[SYNC_STAGES-1];
  assign commit_s = tick_s && (state_q == ST_STOP);

  // Next-state logic; the FSM moves only on a sample strobe.
  always_comb begin
    state_d = state_q;
    if (tick_s) begin
      case (state_q)
        ST_WAIT_IDLE: state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        ST_IDLE:      state_d = rx_s ? ST_IDLE : ST_DATA;
        ST_DATA:      state_d = (cnt_q == 3'd7) ? ST_PARITY : ST_DATA;
        ST_PARITY:    state_d = ST_STOP;
        ST_STOP:      state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        default:      state_d = ST_WAIT_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Line synchroniser, shift datapath and host-side output registers.
  always_ff @(posedge i_Pclk) begin
    if (!i_Rst_n) begin
      rx_sync_q   <= '1;
      state_q     <= ST_WAIT_IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= '1;
      perr_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], i_Rx_Serial};
      state_q   <= state_d;
      busy_q    <= (state_d != ST_IDLE);
      if (tick_s) begin
        case (state_q)
          ST_IDLE: cnt_q <= 3'd0;
          ST_DATA: begin
            shift_q[cnt_q] <= rx_s;
            cnt_q          <= cnt_q + 3'd1;
          end
          ST_PARITY: perr_q <= parity_err(shift_q, rx_s, PARITY_ODD);
          default: ;
        endcase
      end
      // A read landing on the commit cycle consumed the old byte, so no overrun.
      if (commit_s) begin
        data_q      <= shift_q;
        valid_q     <= 1'b1;
        par_err_q   <= perr_q;
        frame_err_q <= ~rx_s;
        overrun_q   <= (i_Read && valid_q) ? 1'b0 : (overrun_q | valid_q);
      end else if (i_Read && valid_q) begin
        valid_q     <= 1'b0;
        par_err_q   <= 1'b0;
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
    end
  end

  assign o_Data       = data_q;
  assign o_Valid      = valid_q;
  assign o_Parity_Err = par_err_q;
  assign o_Frame_Err  = frame_err_q;
  assign o_Overrun    = overrun_q;
  assign o_Busy       = busy_q;

endmodule
